mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback-select logic for the 5-stage RV32I core.
- Captures the MEM-stage result each cycle: ALU result, raw 32-bit word read from data memory, and control.
- Performs load byte/halfword extraction with sign/zero extension and selects the register-file write data.
- Drives the register-file write port and the WB-to-EX forwarding path.

---
 rtl/mem_wb_stage.sv | 124 ++++++++++++
 tb/tb_mem_wb_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback select for the RV32I core.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            RegWrite_in,
  input  logic [1:0]      WbSel_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] ALU_result_in,
  input  logic [XLEN-1:0] MemData_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic            wb_valid,
  output logic            wb_RegWrite,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misaligned
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_count
`endif
);

  logic            valid_q;
  logic            regwrite_q;
  logic [1:0]      wbsel_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] mem_q;
  logic [XLEN-1:0] pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wbsel_q    <= 2'b00;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc4_q      <= '0;
    end else if (flush) begin
      // bubble: only the qualifiers are cleared, payload fields hold
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= in_valid;
      regwrite_q <= RegWrite_in;
      wbsel_q    <= WbSel_in;
      funct3_q   <= funct3_in;
      rd_q       <= rd_in;
      alu_q      <= ALU_result_in;
      mem_q      <= MemData_in;
      pc4_q      <= pc_plus4_in;
    end
  end

  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;
  logic            is_half;
  logic            is_word;

  assign off     = alu_q[1:0];
  assign is_half = (funct3_q == 3'b001) || (funct3_q == 3'b101);
  assign is_word = (funct3_q == 3'b010);

  always_comb begin
    byte_sel = mem_q[7:0];
    case (off)
      2'd0: byte_sel = mem_q[7:0];
      2'd1: byte_sel = mem_q[15:8];
      2'd2: byte_sel = mem_q[23:16];
      2'd3: byte_sel = mem_q[31:24];
      default: byte_sel = mem_q[7:0];
    endcase
  end

  assign half_sel = off[1] ? mem_q[31:16] : mem_q[15:0];

  always_comb begin
    load_val = mem_q;
    case (funct3_q)
      3'b000: load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001: load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100: load_val = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101: load_val = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val = mem_q;
    endcase
  end

  always_comb begin
    wb_data = alu_q;
    case (wbsel_q)
      2'b01:   wb_data = load_val;
      2'b10:   wb_data = pc4_q;
      default: wb_data = alu_q;
    endcase
  end

  assign wb_misaligned = valid_q && (wbsel_q == 2'b01) &&
                         ((is_half && off[0]) || (is_word && (off != 2'd0)));
  assign wb_RegWrite   = valid_q && regwrite_q && (rd_q != 5'd0) && !wb_misaligned;
  assign wb_valid      = valid_q;
  assign wb_rd         = rd_q;

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_count <= '0;
    else if (!stall && !flush && in_valid)
      retire_count <= retire_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

`ifdef RETIRE_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, RegWrite_in;
  logic [1:0]  WbSel_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] ALU_result_in, MemData_in, pc_plus4_in;
  logic        wb_valid, wb_RegWrite, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef RETIRE_CNT_EN
  logic [TB_CNT_W-1:0] retire_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .RegWrite_in(RegWrite_in), .WbSel_in(WbSel_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .ALU_result_in(ALU_result_in),
    .MemData_in(MemData_in), .pc_plus4_in(pc_plus4_in),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned)
`ifdef RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4);
    in_valid = v; RegWrite_in = rw; WbSel_in = sel; funct3_in = f3;
    rd_in = rd; ALU_result_in = alu; MemData_in = mem; pc_plus4_in = pc4;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_mis, input logic exp_we);
    drive(1, 1, 2'b01, f3, 5'd3, addr, 32'h80F17F01, 32'h0);
    step();
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_mis"}, wb_misaligned, exp_mis);
    check({tag, "_we"}, wb_RegWrite, exp_we);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_valid", wb_valid, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_data", wb_data, 0);
    rst_n = 1'b1;

    // hold a valid instruction under stall, then reset asynchronously
    drive(1, 1, 2'b00, 3'b000, 5'd9, 32'hDEAD, 32'h0, 32'h0);
    step();
    check("pre_rst_rd", wb_rd, 9);
    stall = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", wb_valid, 0);
    check("async_we", wb_RegWrite, 0);
    check("async_rd", wb_rd, 0);
    check("async_data", wb_data, 0);
    #3 rst_n = 1'b1;
    stall = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0);
    step();
    check("post_rst_rd", wb_rd, 5);
    check("post_rst_data", wb_data, 32'h1234);
    check("post_rst_we", wb_RegWrite, 1);

    load_chk("lb3",  3'b000, 32'h1003, 32'hFFFFFF80, 0, 1);
    load_chk("lbu3", 3'b100, 32'h1003, 32'h00000080, 0, 1);
    load_chk("lb1",  3'b000, 32'h1001, 32'h0000007F, 0, 1);
    load_chk("lh2",  3'b001, 32'h1002, 32'hFFFF80F1, 0, 1);
    load_chk("lhu0", 3'b101, 32'h1000, 32'h00007F01, 0, 1);
    load_chk("lw0",  3'b010, 32'h1000, 32'h80F17F01, 0, 1);
    load_chk("lh_mis", 3'b001, 32'h0101, 32'hFFFF80F1 & 32'h0000_7F01 | 32'h00007F01, 1, 0);
    load_chk("lw_mis", 3'b010, 32'h0102, 32'h80F17F01, 1, 0);
    load_chk("lb_103", 3'b000, 32'h0103, 32'hFFFFFF80, 0, 1);

    // misalignment only applies to loads
    drive(1, 1, 2'b00, 3'b001, 5'd4, 32'h0101, 32'h80F17F01, 32'h0);
    step();
    check("alu_nomis", wb_misaligned, 0);
    check("alu_nomis_data", wb_data, 32'h0101);

    drive(1, 1, 2'b00, 3'b000, 5'd7, 32'hA, 32'h0, 32'h0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, 3'b000, 5'd9 + 5'(i), 32'hBB + i, 32'h0, 32'h50);
      step();
      check("stall_rd", wb_rd, 7);
      check("stall_data", wb_data, 32'hA);
    end
    flush = 1'b1;
    step();
    check("flush_valid", wb_valid, 0);
    check("flush_we", wb_RegWrite, 0);
    check("flush_rd_hold", wb_rd, 7);
    flush = 1'b0; stall = 1'b0;

    drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h77, 32'h0, 32'h0);
    step();
    check("x0_valid", wb_valid, 1);
    check("x0_we", wb_RegWrite, 0);
    drive(1, 1, 2'b10, 3'b000, 5'd1, 32'h99, 32'h0, 32'h44);
    step();
    check("link_data", wb_data, 32'h44);
    drive(1, 1, 2'b11, 3'b000, 5'd1, 32'h99, 32'h0, 32'h44);
    step();
    check("rsv_sel_data", wb_data, 32'h99);
    drive(0, 1, 2'b00, 3'b000, 5'd2, 32'h5, 32'h0, 32'h0);
    step();
    check("bubble_valid", wb_valid, 0);
    check("bubble_we", wb_RegWrite, 0);

`ifdef RETIRE_CNT_EN
    #2 rst_n = 1'b0;
    #1 check("cnt_rst", retire_count, 0);
    #2 rst_n = 1'b1;
    drive(1, 1, 2'b00, 3'b000, 5'd1, 32'h1, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1; step(); step(); stall = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    in_valid = 1'b0; step(); in_valid = 1'b1;
    // a misaligned load still retires
    drive(1, 1, 2'b01, 3'b010, 5'd1, 32'h2, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("cnt_10", retire_count, 10);
    for (int i = 0; i < 5; i++) step();
    check("cnt_15", retire_count, 15);
    step();
    check("cnt_wrap", retire_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
